// File: rtl/comptest_pkg.sv
// ============================================================================
//  comptest_pkg
//  Shared scan-state encoding, expected-pattern and saturating-increment helpers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package comptest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SETTLE     = 3'd1,
      ST_FIRE       = 3'd2,
      ST_WAIT_LOW   = 3'd3,
      ST_WAIT_READY = 3'd4,
      ST_CHECK      = 3'd5,
      ST_NEXT       = 3'd6,
      ST_FINISH     = 3'd7
   } scan_state_t;

   localparam int c_PAT_W = 256;

   // One-hot word with bit 2*strip+hs_sel set; callers truncate to their width.
   function automatic logic [c_PAT_W-1:0] expected_pattern(input int unsigned strip,
                                                           input logic        hs_sel);
      logic [c_PAT_W-1:0] v_pat;
      v_pat    = '0;
      v_pat[0] = 1'b1;
      return v_pat << (2 * strip + 32'(hs_sel));
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] v_max;
      v_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (val == v_max) ? val : val + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/comp_errcnt_bank.sv
// ============================================================================
//  comp_errcnt_bank
//  Per-strip saturating error counters with clear-all and registered readback.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module comp_errcnt_bank
   import comptest_pkg::*;
#(
   parameter int N_STRIPS = 16,
   parameter int ADR_W    = 4,
   parameter int ERR_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   input  logic [ADR_W-1:0] inc_idx,
   input  logic [ADR_W-1:0] rd_idx,
   output logic [ERR_W-1:0] rd_data
);

   logic [ERR_W-1:0] r_cnt [N_STRIPS];
   logic [ERR_W-1:0] r_rd_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_STRIPS; i++) r_cnt[i] <= '0;
         r_rd_data <= '0;
      end else begin
         if (clr) begin
            for (int i = 0; i < N_STRIPS; i++) r_cnt[i] <= '0;
         end else if (inc && (32'(inc_idx) < N_STRIPS)) begin
            r_cnt[inc_idx] <= ERR_W'(sat_inc(32'(r_cnt[inc_idx]), ERR_W));
         end
         // Readback shows the live count, so it is valid mid-scan.
         r_rd_data <= (32'(rd_idx) < N_STRIPS) ? r_cnt[rd_idx] : '0;
      end
   end

   assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/comp_scan_sequencer.sv
// ============================================================================
//  comp_scan_sequencer
//  Steps the pulser mux over all strips, fires pulses and tallies pattern errors.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module comp_scan_sequencer
   import comptest_pkg::*;
#(
   parameter int N_STRIPS = 16,
   parameter int HS_W     = 32,
   parameter int ADR_W    = 4,
   parameter int NP_W     = 16,
   parameter int ERR_W    = 16,
   parameter int SETTLE_W = 8,
   parameter int TIMEOUT  = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [NP_W-1:0]     n_pulses,
   input  logic [SETTLE_W-1:0] settle_cycles,
   input  logic                hs_sel,
   input  logic [HS_W-1:0]     halfstrips,
   input  logic                pulser_ready,
   output logic                fire_pulse,
   output logic [ADR_W-1:0]    mux_adr,
   output logic                mux_en,
   output logic                busy,
   output logic                done,
   output logic                timeout_flag,
   input  logic [ADR_W-1:0]    rd_strip,
   output logic [ERR_W-1:0]    rd_errcnt
);

   localparam int                c_TO_W       = $clog2(TIMEOUT + 1);
   localparam logic [c_TO_W-1:0] c_TO_LAST    = c_TO_W'(TIMEOUT - 1);
   localparam logic [ADR_W-1:0]  c_LAST_STRIP = ADR_W'(N_STRIPS - 1);

   scan_state_t         r_state;
   logic [ADR_W-1:0]    r_strip;
   logic [NP_W-1:0]     r_npulses;
   logic [NP_W-1:0]     r_pcnt;
   logic [SETTLE_W-1:0] r_settle;
   logic [SETTLE_W-1:0] r_scnt;
   logic [c_TO_W-1:0]   r_tcnt;
   logic                r_hs;
   logic                r_abort;

   logic [HS_W-1:0]     w_exp;
   logic                w_timeout;
   logic                w_account;
   logic                w_last;
   logic                w_abort;
   logic                w_inc;
   logic                w_clr;

   assign w_exp     = HS_W'(expected_pattern(32'(r_strip), r_hs));
   assign w_timeout = ((r_state == ST_WAIT_LOW && pulser_ready) ||
                       (r_state == ST_WAIT_READY && !pulser_ready)) && (r_tcnt == c_TO_LAST);
   assign w_account = (r_state == ST_CHECK) || w_timeout;
   assign w_last    = (r_pcnt + NP_W'(1)) == r_npulses;
   assign w_abort   = r_abort | abort;
   assign w_inc     = ((r_state == ST_CHECK) && (halfstrips != w_exp)) || w_timeout;
   assign w_clr     = (r_state == ST_IDLE) && start;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_strip      <= '0;
         r_npulses    <= '0;
         r_pcnt       <= '0;
         r_settle     <= '0;
         r_scnt       <= '0;
         r_tcnt       <= '0;
         r_hs         <= 1'b0;
         r_abort      <= 1'b0;
         fire_pulse   <= 1'b0;
         mux_adr      <= '0;
         mux_en       <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         if (abort && r_state != ST_IDLE) r_abort <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state      <= ST_SETTLE;
                  busy         <= 1'b1;
                  mux_en       <= 1'b1;
                  done         <= 1'b0;
                  timeout_flag <= 1'b0;
                  r_strip      <= '0;
                  mux_adr      <= '0;
                  r_scnt       <= '0;
                  r_pcnt       <= '0;
                  r_npulses    <= n_pulses;
                  r_settle     <= settle_cycles;
                  r_hs         <= hs_sel;
                  r_abort      <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (w_abort) begin
                  r_state <= ST_FINISH;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  mux_en  <= 1'b0;
               end else if (r_scnt != r_settle) begin
                  r_scnt <= r_scnt + SETTLE_W'(1);
               end else if (r_npulses == '0) begin
                  r_state <= ST_NEXT;
               end else if (pulser_ready) begin
                  r_state    <= ST_FIRE;
                  fire_pulse <= 1'b1;
                  r_pcnt     <= '0;
               end
            end
            ST_FIRE: begin
               fire_pulse <= 1'b0;
               r_tcnt     <= '0;
               r_state    <= ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
               r_tcnt <= r_tcnt + c_TO_W'(1);
               if (!pulser_ready) r_state <= ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
               r_tcnt <= r_tcnt + c_TO_W'(1);
               if (pulser_ready) r_state <= ST_CHECK;
            end
            ST_NEXT: begin
               if (w_abort || r_strip == c_LAST_STRIP) begin
                  r_state <= ST_FINISH;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  mux_en  <= 1'b0;
               end else begin
                  r_strip <= r_strip + ADR_W'(1);
                  mux_adr <= r_strip + ADR_W'(1);
                  r_scnt  <= '0;
                  r_state <= ST_SETTLE;
               end
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
               r_abort <= 1'b0;
            end
            default: r_state <= r_state;
         endcase

         // Pulse accounting after CHECK or a handshake timeout; overrides the case above.
         if (w_account) begin
            r_pcnt <= r_pcnt + NP_W'(1);
            if (w_timeout) timeout_flag <= 1'b1;
            if (w_abort) begin
               r_state <= ST_FINISH;
               done    <= 1'b1;
               busy    <= 1'b0;
               mux_en  <= 1'b0;
            end else if (w_last) begin
               r_state <= ST_NEXT;
            end else begin
               r_state    <= ST_FIRE;
               fire_pulse <= 1'b1;
            end
         end
      end
   end

   comp_errcnt_bank #(
      .N_STRIPS (N_STRIPS),
      .ADR_W    (ADR_W),
      .ERR_W    (ERR_W)
   ) u_errcnt_bank (
      .clock    (clock),
      .reset    (reset),
      .clr      (w_clr),
      .inc      (w_inc),
      .inc_idx  (r_strip),
      .rd_idx   (rd_strip),
      .rd_data  (rd_errcnt)
   );

endmodule

`default_nettype wire

// File: doc/comp_scan_sequencer.md
Name: comp_scan_sequencer

Overview:
Autonomous scan engine for the comparator tester. It steps the pulser mux across N_STRIPS strips and fires a programmable number of pulses per strip through the comparator injector's fire_pulse/pulser_ready handshake. After each pulse it compares the latched half-strip word against the expected one-hot pattern and keeps a saturating error count per strip. Software reads the counts back through the serial register interface. It replaces per-pulse software sequencing over SPI and sits between the serial block, the injector and the mux protector.

Parameters:
N_STRIPS, 16, number of strips scanned; strip index k drives mux address k
HS_W, 32, half-strip word width; must be >= 2*N_STRIPS
ADR_W, 4, mux address width; 2**ADR_W >= N_STRIPS
NP_W, 16, width of pulses-per-strip count
ERR_W, 16, width of each per-strip error counter
SETTLE_W, 8, width of mux settle delay
TIMEOUT, 255, max cycles waiting for pulser_ready to return high

Ports:
clock  in  1  40 MHz system clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins scan when idle, ignored otherwise
abort  in  1  one-cycle pulse; ends the scan at the next state boundary
n_pulses  in  NP_W  pulses per strip; 0 means skip firing, strip gets 0 errors
settle_cycles  in  SETTLE_W  idle cycles after each mux address change
hs_sel  in  1  expected half-strip within strip k: bit 2k+hs_sel
halfstrips  in  HS_W  latched half-strip word from the injector
pulser_ready  in  1  injector idle
fire_pulse  out  1  one-cycle pulse request to the injector
mux_adr  out  ADR_W  pulser mux address
mux_en  out  1  mux enable request, high from SETTLE through CHECK
busy  out  1  scan in progress
done  out  1  sticky; set at scan end, cleared by start or reset
timeout_flag  out  1  sticky; set on any handshake timeout, cleared by start
rd_strip  in  ADR_W  readback strip index
rd_errcnt  out  ERR_W  error count for rd_strip, registered, 1-cycle latency; 0 if rd_strip >= N_STRIPS

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, all error counters 0, strip index 0, pulse count 0.
- FSM states: IDLE, SETTLE, FIRE, WAIT_LOW, WAIT_READY, CHECK, NEXT, FINISH.
- IDLE: on start, clear all error counters, done and timeout_flag; strip index = 0; mux_adr = 0; go to SETTLE. busy rises on the cycle after start.
- SETTLE: count settle_cycles cycles. If n_pulses == 0, go to NEXT. Otherwise go to FIRE once pulser_ready = 1.
- FIRE: assert fire_pulse for exactly one cycle, then go to WAIT_LOW.
- WAIT_LOW: wait for pulser_ready = 0.
- WAIT_READY: wait for pulser_ready = 1.
- Shared timeout counter for WAIT_LOW + WAIT_READY: after TIMEOUT cycles, set timeout_flag, count the pulse as an error, and go to CHECK-skip, i.e. straight to the pulse accounting.
- CHECK: error if halfstrips != (1 << (2k + hs_sel)). This catches both missing and extra hits.
- Error counters saturate at 2**ERR_W - 1 and never wrap.
- Pulse accounting: increment the pulse count. If count == n_pulses, go to NEXT; else go to FIRE. No settle is inserted between repeated pulses.
- NEXT: if k == N_STRIPS-1, go to FINISH. Otherwise k++, mux_adr = k, go to SETTLE.
- FINISH: set done, drop busy and mux_en, go to IDLE.
- abort: latched. It takes effect in SETTLE, in NEXT, or after the pulse accounting completes, and then goes to FINISH. It never cuts a handshake or a fire_pulse. Counts already accumulated are preserved.
- start while busy: ignored. Simultaneous start and abort in IDLE: start wins and abort is dropped.
- Inputs are sampled at scan start for the whole scan: n_pulses, settle_cycles, hs_sel.
- rd_errcnt is readable at any time, including mid-scan. It returns the live counter value.
- Reset mid-scan: immediate return to the reset state. fire_pulse deasserts asynchronously.

Decomposition:
- Shared package comptest_pkg holds:
  - FSM state encoding constants.
  - The expected-pattern function (strip index, hs_sel -> one-hot HS_W word).
  - Saturating-increment helper.
- One sub-module: comp_errcnt_bank. It holds N_STRIPS x ERR_W saturating counters with clear-all, increment-at-index and registered read port.

Test Plan:
- Scan with 4 pulses per strip, all strips clean: N_STRIPS=16, n_pulses=4, settle_cycles=3, hs_sel=0; injector model returns halfstrips = 1<<(2k) 5 cycles after each fire -> 64 fire_pulse pulses; mux_adr steps 0..15; all rd_errcnt = 0; done=1; timeout_flag=0.
- Injected errors on strip 5: n_pulses=10; model returns 0 for strip 5 pulses 3 and 7, and returns extra bit 31 on strip 9 pulse 0 -> rd_errcnt(5)=2, rd_errcnt(9)=1, all others 0.
- Timeout: model keeps pulser_ready low forever on strip 2 -> after 255 cycles timeout_flag=1 and rd_errcnt(2) = n_pulses; scan completes through strip 15.
- Saturation: ERR_W=4, n_pulses=20, strip 0 always wrong -> rd_errcnt(0)=15, no wrap.
- Abort: abort asserted during WAIT_READY of strip 3 -> the in-flight pulse is accounted, no further fire_pulse, done=1 within 2 cycles after WAIT_READY exits, strips 4..15 read 0.
- Reset mid-scan and restart: assert reset during strip 7 -> all outputs 0; new start after reset re-scans from strip 0 with counters cleared; start pulses while busy cause no effect.
